// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: owns the PC, keeps several ROM fetches in flight and buffers the returned
// words in a DEPTH-entry prefetch queue. Define IFETCH_PERF_EN for stall/flush counter ports.
module ifetch_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter logic [INST_W-1:0] NOP      = INST_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [INST_W-1:0] rom_rdata_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(PC_STEP - 1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_fl;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_alloc_cnt;
    logic [CNT_W-1:0]  r_pend_cnt;
    logic [CNT_W-1:0]  r_discard_cnt;
    logic [DEPTH-1:0]  r_filled;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [INST_W-1:0] r_data [DEPTH];

    logic              w_req;
    logic              w_accept;
    logic              w_drop;
    logic              w_fill;
    logic              w_valid;
    logic              w_pop;
    logic [CNT_W:0]    w_inflight;
    logic [DEPTH-1:0]  w_filled_next;

    // r_pend_cnt tracks granted-but-unreturned live requests, so a flush knows how many
    // responses are still owed by the ROM and must be dropped.
    assign w_inflight = {1'b0, r_alloc_cnt} + {1'b0, r_discard_cnt};
    assign w_req      = rst_n && !jump_en_i && (w_inflight < DEPTH_C);
    assign w_accept   = w_req && rom_gnt_i;
    assign w_drop     = rom_rvalid_i && (jump_en_i || (r_discard_cnt != '0));
    assign w_fill     = rom_rvalid_i && !w_drop;
    assign w_valid    = r_filled[r_rd];
    assign w_pop      = w_valid && !hold_flag_i && !jump_en_i;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
            assign w_filled_next[gi] = (w_fill && (r_fl == PTR_W'(gi))) ||
                                       (r_filled[gi] &&
                                        !(w_accept && (r_wr == PTR_W'(gi))) &&
                                        !(w_pop && (r_rd == PTR_W'(gi))));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_wr          <= '0;
            r_fl          <= '0;
            r_rd          <= '0;
            r_alloc_cnt   <= '0;
            r_pend_cnt    <= '0;
            r_discard_cnt <= '0;
            r_filled      <= '0;
        end else if (jump_en_i) begin
            // Any response this cycle is dropped, whether it was stale or the oldest live one.
            r_pc          <= jump_addr_i & ~STEP_MASK;
            r_wr          <= '0;
            r_fl          <= '0;
            r_rd          <= '0;
            r_alloc_cnt   <= '0;
            r_pend_cnt    <= '0;
            r_discard_cnt <= r_discard_cnt + r_pend_cnt - CNT_W'(rom_rvalid_i);
            r_filled      <= '0;
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
                r_wr <= r_wr + 1'b1;
            end
            if (w_fill) r_fl <= r_fl + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_alloc_cnt   <= r_alloc_cnt + CNT_W'(w_accept) - CNT_W'(w_pop);
            r_pend_cnt    <= r_pend_cnt + CNT_W'(w_accept) - CNT_W'(w_fill);
            r_discard_cnt <= r_discard_cnt - CNT_W'(w_drop);
            r_filled      <= w_filled_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_addr[r_wr] <= r_pc;
        if (w_fill)   r_data[r_fl] <= rom_rdata_i;
    end

    assign rom_req_o    = w_req;
    assign rom_addr_o   = r_pc;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_data[r_rd] : NOP;
    assign inst_addr_o  = w_valid ? r_addr[r_rd] : '0;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_valid && !hold_flag_i && !jump_en_i && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_drop && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: an in-order variable-latency ROM environment plus a
// queue-based reference model of the expected PC / instruction stream.
module tb_ifetch_prefetch;
    localparam int          ADDR_W  = 32;
    localparam int          INST_W  = 32;
    localparam int          DEPTH   = 4;
    localparam int          PC_STEP = 4;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        jump_en = 1'b0;
    logic [31:0] jaddr = '0;
    logic        hold = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    ifetch_prefetch #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH),
        .RESET_PC(32'h0), .PC_STEP(PC_STEP), .NOP(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(gnt),
        .rom_rvalid_i(rvalid), .rom_rdata_i(rdata),
        .jump_en_i(jump_en), .jump_addr_i(jaddr), .hold_flag_i(hold),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
`ifdef IFETCH_PERF_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } rom_t;

    rom_t        rom_q[$];
    int          cyc;
    int          rom_lat = 1;
    bit          rom_rand = 1'b0;

    // Reference model: expected PC, queue of allocated addresses (oldest first),
    // how many of the oldest are filled, and how many ROM responses are owed but stale.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    int          m_nfill;
    int          m_disc;

    logic        e_req, e_valid;
    logic [31:0] e_addr, e_inst, e_iaddr;

    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic eval_model();
        e_req   = rst_n && !jump_en && ((m_q.size() + m_disc) < DEPTH);
        e_addr  = m_pc;
        e_valid = (m_nfill > 0);
        e_iaddr = e_valid ? m_q[0] : 32'h0;
        e_inst  = e_valid ? rom_word(m_q[0]) : NOP;
    endtask

    // Called at the negedge: applies this cycle's edge to ROM and model, then moves to posedge+1.
    task automatic advance();
        rom_t e;
        bit   acc_m;
        eval_model();
        acc_m = e_req && gnt;
        if (rvalid) void'(rom_q.pop_front());
        if (rst_n && rom_req_o && gnt) begin
            e.addr  = rom_addr_o;
            e.ready = cyc + (rom_rand ? int'($urandom_range(1, 4)) : rom_lat);
            rom_q.push_back(e);
        end
        if (jump_en) begin
            m_disc  = m_disc + (m_q.size() - m_nfill) - (rvalid ? 1 : 0);
            m_q.delete();
            m_nfill = 0;
            m_pc    = jaddr & ~32'h3;
        end else begin
            if (rvalid) begin
                if (m_disc > 0) m_disc--;
                else m_nfill++;
            end
            if (e_valid && !hold) begin
                void'(m_q.pop_front());
                m_nfill--;
            end
            if (acc_m) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + PC_STEP;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        rvalid = 1'b0;
        rdata  = '0;
        if (rom_q.size() > 0 && rom_q[0].ready <= cyc &&
            (!rom_rand || $urandom_range(0, 3) != 0)) begin
            rvalid = 1'b1;
            rdata  = rom_word(rom_q[0].addr);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        jump_en = 1'b0; hold = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; jaddr = '0;
        rom_q.delete();
        m_q.delete();
        m_pc = 32'h0; m_nfill = 0; m_disc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        gnt = 1'b1;
        #2;
        n_tests++;
        if (rom_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_init req=%b valid=%b inst=%h iaddr=%h (need 0,0,%h,0)",
                     rom_req_o, inst_valid_o, inst_o, inst_addr_o, NOP);
        end
        do_reset();
        rom_rand = 1'b0; rom_lat = 1;
        @(negedge clk);
        n_tests++;
        if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req req=%b addr=%h (need 1,0)", rom_req_o, rom_addr_o);
        end
        for (int c = 0; c < 6; c++) begin
            gnt = 1'b1;
            if (c > 0) @(negedge clk);
            advance();
        end
        // Assert reset with words buffered and responses in flight.
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (rom_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP ||
            inst_addr_o !== 32'h0 || rom_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_midflight req=%b valid=%b inst=%h iaddr=%h pc=%h",
                     rom_req_o, inst_valid_o, inst_o, inst_addr_o, rom_addr_o);
        end
        $display("[TB] reset checks done");
    endtask

    task automatic test_stream();
        int first_v = -1;
        int nvalid = 0;
        rom_rand = 1'b0; rom_lat = 1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            gnt = 1'b1; hold = 1'b0; jump_en = 1'b0;
            @(negedge clk);
            eval_model();
            n_tests++;
            if (rom_req_o !== e_req || rom_addr_o !== e_addr || inst_valid_o !== e_valid ||
                inst_o !== e_inst || inst_addr_o !== e_iaddr) begin
                n_fail++;
                $display("FAIL stream c=%0d req=%b/%b addr=%h/%h v=%b/%b inst=%h/%h ia=%h/%h",
                         c, rom_req_o, e_req, rom_addr_o, e_addr, inst_valid_o, e_valid,
                         inst_o, e_inst, inst_addr_o, e_iaddr);
            end
            if (inst_valid_o === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                nvalid++;
            end
            advance();
        end
        n_tests++;
        if (first_v != 2) begin
            n_fail++;
            $display("FAIL stream_first_valid cycle=%0d need 2", first_v);
        end
        n_tests++;
        if (nvalid != 10) begin
            n_fail++;
            $display("FAIL stream_rate valid_cycles=%0d need 10", nvalid);
        end
        $display("[TB] stream: first valid at cycle %0d, %0d valid cycles", first_v, nvalid);
    endtask

    task automatic test_hold_full();
        int          grants = 0;
        logic [31:0] pops[$];
        logic [31:0] first_req = 32'hFFFFFFFF;
        bit          seen_req = 1'b0;
        rom_rand = 1'b0; rom_lat = 1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            gnt = 1'b1; hold = 1'b1;
            @(negedge clk);
            if (rom_req_o === 1'b1) grants++;
            if (c == 9) begin
                n_tests++;
                if (rom_req_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_req_stalled req=%b need 0", rom_req_o);
                end
            end
            advance();
        end
        n_tests++;
        if (grants != DEPTH) begin
            n_fail++;
            $display("FAIL hold_grants got=%0d need %0d", grants, DEPTH);
        end
        for (int c = 0; c < 8; c++) begin
            gnt = 1'b1; hold = 1'b0;
            @(negedge clk);
            if (inst_valid_o === 1'b1) pops.push_back(inst_addr_o);
            if (rom_req_o === 1'b1 && !seen_req) begin
                seen_req = 1'b1;
                first_req = rom_addr_o;
            end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (pops.size() <= i || pops[i] !== 32'(i * PC_STEP)) begin
                n_fail++;
                $display("FAIL hold_pop_order idx=%0d got=%h need %h", i,
                         (pops.size() > i) ? pops[i] : 32'hDEADBEEF, 32'(i * PC_STEP));
            end
        end
        n_tests++;
        if (first_req !== 32'h10) begin
            n_fail++;
            $display("FAIL hold_resume_addr got=%h need 00000010", first_req);
        end
        $display("[TB] hold_full: %0d grants, resumed at %h", grants, first_req);
    endtask

    task automatic test_jump_flush();
        bit found = 1'b0;
        rom_rand = 1'b0; rom_lat = 3;
        do_reset();
        for (int c = 0; c < 21; c++) begin
            gnt     = (c != 3);
            jump_en = (c == 3);
            jaddr   = 32'h100;
            @(negedge clk);
            eval_model();
            n_tests++;
            if (rom_req_o !== e_req || rom_addr_o !== e_addr || inst_valid_o !== e_valid ||
                inst_o !== e_inst || inst_addr_o !== e_iaddr) begin
                n_fail++;
                $display("FAIL jump_flush c=%0d req=%b/%b addr=%h/%h v=%b/%b inst=%h/%h ia=%h/%h",
                         c, rom_req_o, e_req, rom_addr_o, e_addr, inst_valid_o, e_valid,
                         inst_o, e_inst, inst_addr_o, e_iaddr);
            end
            if (c > 3 && inst_valid_o === 1'b1 && !found) begin
                found = 1'b1;
                n_tests++;
                if (inst_addr_o !== 32'h100 || inst_o !== rom_word(32'h100)) begin
                    n_fail++;
                    $display("FAIL jump_first_head addr=%h inst=%h need 00000100 %h",
                             inst_addr_o, inst_o, rom_word(32'h100));
                end
            end
            advance();
        end
        jump_en = 1'b0;
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL jump_flush_timeout no valid head within 17 cycles after jump");
        end
`ifdef IFETCH_PERF_EN
        n_tests++;
        if (flush_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_flush_cnt got=%0d need 3", flush_cnt);
        end
`endif
        $display("[TB] jump_flush: head after jump found=%0b", found);
    endtask

    task automatic test_jump_misaligned();
        bit found = 1'b0;
        rom_rand = 1'b0; rom_lat = 1;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            gnt = 1'b1;
            @(negedge clk);
            advance();
        end
        // rvalid is active in this cycle (response for 0x8) and must be dropped.
        gnt = 1'b1; jump_en = 1'b1; jaddr = 32'h103;
        @(negedge clk);
        advance();
        jump_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h100) begin
            n_fail++;
            $display("FAIL misalign_addr req=%b addr=%h need 1 00000100", rom_req_o, rom_addr_o);
        end
        n_tests++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL misalign_drop valid=%b inst=%h ia=%h need 0 %h 0",
                     inst_valid_o, inst_o, inst_addr_o, NOP);
        end
        advance();
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (inst_valid_o === 1'b1) begin
                found = 1'b1;
                n_tests++;
                if (inst_addr_o !== 32'h100 || inst_o !== rom_word(32'h100)) begin
                    n_fail++;
                    $display("FAIL misalign_head addr=%h inst=%h need 00000100 %h",
                             inst_addr_o, inst_o, rom_word(32'h100));
                end
            end
            advance();
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL misalign_timeout no valid head within 10 cycles");
        end
        $display("[TB] jump_misaligned: head found=%0b", found);
    endtask

    task automatic test_random();
        int npops = 0;
        int nerr = 0;
        rom_rand = 1'b1;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            gnt     = ($urandom_range(0, 2) != 0);
            hold    = ($urandom_range(0, 3) == 0);
            jump_en = ($urandom_range(0, 39) == 0);
            jaddr   = $urandom;
            @(negedge clk);
            eval_model();
            n_tests++;
            if (rom_req_o !== e_req || rom_addr_o !== e_addr || inst_valid_o !== e_valid ||
                inst_o !== e_inst || inst_addr_o !== e_iaddr) begin
                n_fail++;
                nerr++;
                $display("FAIL random c=%0d req=%b/%b addr=%h/%h v=%b/%b inst=%h/%h ia=%h/%h",
                         c, rom_req_o, e_req, rom_addr_o, e_addr, inst_valid_o, e_valid,
                         inst_o, e_inst, inst_addr_o, e_iaddr);
            end
            if (e_valid && !hold && !jump_en) npops++;
            advance();
        end
        jump_en = 1'b0; hold = 1'b0;
        n_tests++;
        if (npops < 500) begin
            n_fail++;
            $display("FAIL random_throughput pops=%0d need >=500", npops);
        end
        rom_rand = 1'b0;
        $display("[TB] random: 10000 cycles, %0d instructions delivered, %0d bad cycles", npops, nerr);
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf_stall();
        rom_rand = 1'b0; rom_lat = 1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            gnt = 1'b0; hold = 1'b0;
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        n_tests++;
        if (stall_cnt < 32'd5 || stall_cnt > 32'd6) begin
            n_fail++;
            $display("FAIL perf_stall_cnt got=%0d need 5..6", stall_cnt);
        end
        $display("[TB] perf_stall: stall_cnt=%0d", stall_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_hold_full();
        test_jump_flush();
        test_jump_misaligned();
        test_random();
`ifdef IFETCH_PERF_EN
        test_perf_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
